gcd_unit: RTL and testbench
===========================

# gcd_unit

Parametrised, self-contained GCD engine: operand registers, datapath and controller in one block. Computes gcd(a, b) of two unsigned WIDTH-bit operands with the binary (Stein) algorithm, one reduction step per cycle. It adds zero-operand handling, an iteration counter and a level go/done handshake. It sits under a host controller that presents operands, raises `go`, waits for `done`, then lowers `go`.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 2)
- CNT_W, 8, width of the iteration counter (≥ 1)
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- go  input  1  request; level-sensitive, sampled in IDLE/DONE
- a_in  input  WIDTH  operand A, captured on accept
- b_in  input  WIDTH  operand B, captured on accept
- ready  output  1  high in IDLE
- busy  output  1  high in STRIP or REDUCE
- done  output  1  high in DONE; result and cycles valid
- result  output  WIDTH  gcd(a, b); held in DONE
- cycles  output  CNT_W  STRIP+REDUCE cycles used; saturates at all-ones

## Operation
- Registers: x, y (WIDTH), shift ($clog2(WIDTH) bits), cnt (CNT_W), state.
- IDLE: ready=1.
  - go=1 → accept: x←a_in, y←b_in, shift←0, cnt←0.
  - Either operand is zero → DONE directly; result←a_in|b_in (gcd(0,b)=b, gcd(0,0)=0), cycles=0.
  - Otherwise → STRIP.
- STRIP, one cycle each, cnt+1:
  - x[0]=0 and y[0]=0 → x←x>>1, y←y>>1, shift+1, stay.
  - Otherwise → REDUCE, with no data change.
- REDUCE, one cycle each, cnt+1; priority order:
  - x even → x←x>>1.
  - Else y even → y←y>>1.
  - Else x==y → result←x<<shift; → DONE.
  - Else x<y → y←y−x.
  - Else → x←x−y.
- Subtractions are performed only when the minuend is strictly larger, so there is no underflow and no carry-out. The final shift never overflows WIDTH, because result ≤ min(a, b).
- cnt saturates at 2^CNT_W−1 and never wraps.
- DONE: done=1. result and cycles are held stable while go=1. go=0 → IDLE next cycle.
- A new request therefore needs go to drop for at least one cycle. go held high through DONE never restarts the unit.
- a_in/b_in are ignored outside the accept cycle.
- Exactly one of ready, busy, done is high in any cycle.

## Timing
- Reset: state=IDLE; ready=1, busy=0, done=0, result=0, cycles=0; x, y, shift, cnt cleared.
- Reset takes priority over every transition. Reset mid-computation aborts it with no done pulse and returns to IDLE on the next edge.
- Accept at edge T (IDLE, go=1). Nonzero operands: busy from T+1; done rises at T+1+N, where N is the final cycles value. Zero operand: done at T+1.
- Outputs are registered; no combinational path from go/a_in/b_in to any output.
- result/cycles update only on the edge entering DONE. They keep their last values in IDLE until the next completion.

## Structure
- Package gcd_pkg holds:
  - the state enum {IDLE, STRIP, REDUCE, DONE} (2 bits);
  - default parameter constants.
- One sub-module, gcd_datapath:
  - contains x/y/shift registers, the comparator (x_lt_y, x_eq_y), the subtractor and the shifters;
  - is driven by load/strip/sub_x/sub_y/half_x/half_y strobes.
- The controller FSM and saturating counter stay in gcd_unit.

## Test plan
- WIDTH=16: a=48, b=18, go held → busy for 8 cycles, done at T+9, result=6, cycles=8; go dropped → ready next cycle.
- a=0, b=5 → done at T+1, result=5, cycles=0. a=0, b=0 → result=0.
- a=7, b=7 → cycles=2, result=7. Swap check: a=18, b=48 → result=6.
- WIDTH=8, a=255, b=1 → result=1, cycles=16. Same run with CNT_W=4 → cycles=15 (saturated).
- Reset asserted on the 3rd busy cycle → next cycle ready=1, done=0, result=0, cycles=0, and done never pulses. A following request a=48, b=18 completes correctly.
- go held high for 5 cycles after done → done stays high, result is stable, no restart. Randomised WIDTH=16 pairs are checked against a reference gcd model.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and default parameters for the binary-GCD engine.
package gcd_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_if.sv
// Host <-> GCD engine handshake and operand/result bundle.
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             go;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cycles;

    modport master (
        output go, a_in, b_in,
        input  ready, busy, done, result, cycles
    );

    modport slave (
        input  go, a_in, b_in,
        output ready, busy, done, result, cycles
    );
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, comparator, subtractor and shifters for Stein's GCD.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             strip,
    input  logic             sub_x,
    input  logic             sub_y,
    input  logic             half_x,
    input  logic             half_y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             x_even,
    output logic             y_even,
    output logic             x_lt_y,
    output logic             x_eq_y,
    output logic [WIDTH-1:0] gcd_val
);
    // Common factors of two removed while stripping never exceed WIDTH-1.
    localparam int unsigned SH_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [SH_W-1:0]  shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            shift <= '0;
        end else if (load) begin
            x     <= a;
            y     <= b;
            shift <= '0;
        end else if (strip) begin
            x     <= x >> 1;
            y     <= y >> 1;
            shift <= shift + SH_W'(1);
        end else begin
            if (half_x)     x <= x >> 1;
            else if (sub_x) x <= x - y;
            if (half_y)     y <= y >> 1;
            else if (sub_y) y <= y - x;
        end
    end

    assign x_even  = ~x[0];
    assign y_even  = ~y[0];
    assign x_lt_y  = (x < y);
    assign x_eq_y  = (x == y);
    assign gcd_val = x << shift;

endmodule

// File: rtl/gcd_unit.sv
// Binary GCD engine: go/done controller, saturating step counter and result registers.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic   clock,
    input logic   reset,
    gcd_if.slave  bus
);
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic load, strip, sub_x, sub_y, half_x, half_y;
    logic finish_zero, finish_calc;
    logic x_even, y_even, x_lt_y, x_eq_y;
    logic [WIDTH-1:0] gcd_val;

    gcd_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .strip   (strip),
        .sub_x   (sub_x),
        .sub_y   (sub_y),
        .half_x  (half_x),
        .half_y  (half_y),
        .a       (bus.a_in),
        .b       (bus.b_in),
        .x_even  (x_even),
        .y_even  (y_even),
        .x_lt_y  (x_lt_y),
        .x_eq_y  (x_eq_y),
        .gcd_val (gcd_val)
    );

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Next state and datapath strobes.
    always_comb begin
        state_nx    = state;
        load        = 1'b0;
        strip       = 1'b0;
        sub_x       = 1'b0;
        sub_y       = 1'b0;
        half_x      = 1'b0;
        half_y      = 1'b0;
        finish_zero = 1'b0;
        finish_calc = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.go) begin
                    load = 1'b1;
                    if (bus.a_in == '0 || bus.b_in == '0) begin
                        finish_zero = 1'b1;
                        state_nx    = DONE;
                    end else begin
                        state_nx = STRIP;
                    end
                end
            end
            STRIP: begin
                if (x_even && y_even) strip    = 1'b1;
                else                  state_nx = REDUCE;
            end
            REDUCE: begin
                if (x_even)      half_x = 1'b1;
                else if (y_even) half_y = 1'b1;
                else if (x_eq_y) begin
                    finish_calc = 1'b1;
                    state_nx    = DONE;
                end
                else if (x_lt_y) sub_y = 1'b1;
                else             sub_x = 1'b1;
            end
            DONE: begin
                if (!bus.go) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bus.result <= '0;
            bus.cycles <= '0;
            bus.ready  <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            state     <= state_nx;
            bus.ready <= (state_nx == IDLE);
            bus.busy  <= (state_nx == STRIP) || (state_nx == REDUCE);
            bus.done  <= (state_nx == DONE);

            if (load)                                      cnt <= '0;
            else if (state == STRIP || state == REDUCE)    cnt <= cnt_inc;

            // Results change only on the edge that enters DONE.
            if (finish_zero) begin
                bus.result <= bus.a_in | bus.b_in;
                bus.cycles <= '0;
            end else if (finish_calc) begin
                bus.result <= gcd_val;
                bus.cycles <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_gcd_unit.sv
// Directed-vector and random-reference bench for gcd_unit.
module tb_gcd_unit;
    import gcd_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gcd_if #(.WIDTH(16), .CNT_W(8)) bus16 ();
    gcd_if #(.WIDTH(8),  .CNT_W(8)) bus8  ();
    gcd_if #(.WIDTH(8),  .CNT_W(4)) bus8s ();

    gcd_unit #(.WIDTH(16), .CNT_W(8)) u16  (.clock(clock), .reset(reset), .bus(bus16));
    gcd_unit #(.WIDTH(8),  .CNT_W(8)) u8   (.clock(clock), .reset(reset), .bus(bus8));
    gcd_unit #(.WIDTH(8),  .CNT_W(4)) u8s  (.clock(clock), .reset(reset), .bus(bus8s));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [7:0]  cyc;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Presents operands with go high; operands are scrambled after the accept edge.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input int budget,
                         output int lat, output int nbusy);
        bit seen;
        seen  = 0;
        lat   = -1;
        nbusy = 0;
        bus16.a_in = a;
        bus16.b_in = b;
        bus16.go   = 1'b1;
        for (int k = 1; k <= budget && !seen; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin
                bus16.a_in = ~a;
                bus16.b_in = a ^ b;
            end
            chk("onehot", 32'(bus16.ready) + 32'(bus16.busy) + 32'(bus16.done), 1);
            if (bus16.busy) nbusy++;
            if (bus16.done) begin
                lat  = k;
                seen = 1;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic release16();
        bus16.go = 1'b0;
        @(posedge clock); #1;
        chk("ready_after_drop", 32'(bus16.ready), 1);
        chk("done_after_drop",  32'(bus16.done), 0);
    endtask

    vec_t vecs[8];
    int   lat, nbusy;
    logic [15:0] ra, rb, held_res;
    logic [7:0]  held_cyc;
    int   lat8, lat8s;
    bit   saw_done;

    initial begin
        vecs[0] = '{16'd48,    16'd18,    16'd6,     8'd8};
        vecs[1] = '{16'd0,     16'd5,     16'd5,     8'd0};
        vecs[2] = '{16'd0,     16'd0,     16'd0,     8'd0};
        vecs[3] = '{16'd7,     16'd7,     16'd7,     8'd2};
        vecs[4] = '{16'd18,    16'd48,    16'd6,     8'd8};
        vecs[5] = '{16'd5,     16'd0,     16'd5,     8'd0};
        vecs[6] = '{16'd12,    16'd8,     16'd4,     8'd7};
        vecs[7] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  8'd2};

        bus16.go = 0; bus16.a_in = 0; bus16.b_in = 0;
        bus8.go  = 0; bus8.a_in  = 0; bus8.b_in  = 0;
        bus8s.go = 0; bus8s.a_in = 0; bus8s.b_in = 0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready",  32'(bus16.ready), 1);
        chk("rst_busy",   32'(bus16.busy), 0);
        chk("rst_done",   32'(bus16.done), 0);
        chk("rst_result", 32'(bus16.result), 0);
        chk("rst_cycles", 32'(bus16.cycles), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) begin
            run16(vecs[i].a, vecs[i].b, 100, lat, nbusy);
            chk($sformatf("v%0d_result", i), 32'(bus16.result), 32'(vecs[i].res));
            chk($sformatf("v%0d_cycles", i), 32'(bus16.cycles), 32'(vecs[i].cyc));
            chk($sformatf("v%0d_latency", i), lat, 32'(vecs[i].cyc) + 1);
            chk($sformatf("v%0d_busy_cnt", i), nbusy, 32'(vecs[i].cyc));
            release16();
        end

        // go held through DONE must not restart and must hold outputs.
        run16(16'd48, 16'd18, 100, lat, nbusy);
        held_res = bus16.result;
        held_cyc = bus16.cycles;
        chk("hold_first_result", 32'(held_res), 6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("hold_done",   32'(bus16.done), 1);
            chk("hold_busy",   32'(bus16.busy), 0);
            chk("hold_result", 32'(bus16.result), 6);
            chk("hold_cycles", 32'(bus16.cycles), 8);
        end
        release16();

        // Reset on the third busy cycle aborts without a done pulse.
        bus16.a_in = 16'd48; bus16.b_in = 16'd18; bus16.go = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
        end
        chk("pre_abort_busy", 32'(bus16.busy), 1);
        reset    = 1'b1;
        bus16.go = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_ready",  32'(bus16.ready), 1);
        chk("abort_done",   32'(bus16.done), 0);
        chk("abort_result", 32'(bus16.result), 0);
        chk("abort_cycles", 32'(bus16.cycles), 0);
        saw_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (bus16.done) saw_done = 1;
        end
        chk("abort_no_done", 32'(saw_done), 0);
        run16(16'd48, 16'd18, 100, lat, nbusy);
        chk("post_abort_result", 32'(bus16.result), 6);
        chk("post_abort_cycles", 32'(bus16.cycles), 8);
        chk("post_abort_latency", lat, 9);
        release16();

        // Narrow instances: long subtract chain and counter saturation.
        bus8.a_in  = 8'd255; bus8.b_in  = 8'd1; bus8.go  = 1'b1;
        bus8s.a_in = 8'd255; bus8s.b_in = 8'd1; bus8s.go = 1'b1;
        lat8 = -1; lat8s = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            if (bus8.done  && lat8  < 0) lat8  = k;
            if (bus8s.done && lat8s < 0) lat8s = k;
        end
        chk("w8_latency",     lat8, 17);
        chk("w8_result",      32'(bus8.result), 1);
        chk("w8_cycles",      32'(bus8.cycles), 16);
        chk("w8s_latency",    lat8s, 17);
        chk("w8s_result",     32'(bus8s.result), 1);
        chk("w8s_cycles_sat", 32'(bus8s.cycles), 15);
        bus8.go = 1'b0; bus8s.go = 1'b0;
        @(posedge clock); #1;
        chk("w8_ready",  32'(bus8.ready), 1);
        chk("w8s_ready", 32'(bus8s.ready), 1);

        // Random pairs against a Euclid reference.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if (i % 5 == 0) rb = ra ^ 16'($urandom_range(0, 15));
            run16(ra, rb, 300, lat, nbusy);
            chk($sformatf("rand%0d_gcd(%0d,%0d)", i, ra, rb), 32'(bus16.result), 32'(ref_gcd(ra, rb)));
            chk($sformatf("rand%0d_latency", i), lat, 32'(bus16.cycles) + 1);
            release16();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
